// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci sequence generator.
package fib_pkg;

    localparam int FIB_WIDTH_DEF = 32;
    localparam int FIB_IDX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fib_state_t;

endpackage

// File: rtl/fib_seq_gen_step.sv
// Combinational Fibonacci step: next term and its sticky overflow flag.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_a_flag,
    input  logic             i_b_flag,
    output logic [WIDTH-1:0] o_b_next,
    output logic             o_b_next_flag
);

    logic [WIDTH:0] w_sum;

    assign w_sum         = {1'b0, i_a} + {1'b0, i_b};
    assign o_b_next      = w_sum[WIDTH-1:0];
    // Once a term has overflowed, every later term is derived from it and is flagged too.
    assign o_b_next_flag = w_sum[WIDTH] | i_a_flag | i_b_flag;

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term streamer with programmable seeds/count and valid/ready output.
// Define FIB_SAT_EN to saturate overflowed terms to all-ones and end the run on the first one.
module fib_seq_gen
    import fib_pkg::*;
#(
    parameter int WIDTH = FIB_WIDTH_DEF,
    parameter int IDX_W = FIB_IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    input  logic [IDX_W-1:0] num_terms,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    // IDLE: wait for start | RUN: present term a, advance on handshake | DONE: one-cycle done pulse
    fib_state_t       r_state;
    fib_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_flag;
    logic             r_b_flag;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_remaining;
    logic             r_overflow;

    logic [WIDTH-1:0] w_b_next;
    logic             w_b_next_flag;
    logic [WIDTH-1:0] w_term;
    logic             w_sat_stop;
    logic             w_accept;
    logic             w_hs;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .i_a           (r_a),
        .i_b           (r_b),
        .i_a_flag      (r_a_flag),
        .i_b_flag      (r_b_flag),
        .o_b_next      (w_b_next),
        .o_b_next_flag (w_b_next_flag)
    );

`ifdef FIB_SAT_EN
    assign w_term     = r_a_flag ? {WIDTH{1'b1}} : r_a;
    assign w_sat_stop = r_a_flag;
`else
    assign w_term     = r_a;
    assign w_sat_stop = 1'b0;
`endif

    assign w_accept = (r_state == IDLE) && start;
    assign w_hs     = (r_state == RUN) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_data    = '0;
        out_idx     = '0;
        busy        = 1'b0;
        done        = 1'b0;
        overflow    = r_overflow;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_terms != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                out_valid = 1'b1;
                out_data  = w_term;
                out_idx   = r_idx;
                busy      = 1'b1;
                overflow  = r_overflow | r_a_flag;
                if (out_ready && ((r_remaining == IDX_W'(1)) || w_sat_stop)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_a_flag    <= 1'b0;
            r_b_flag    <= 1'b0;
            r_idx       <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a         <= seed0;
            r_b         <= seed1;
            r_a_flag    <= 1'b0;
            r_b_flag    <= 1'b0;
            r_idx       <= '0;
            r_remaining <= num_terms;
            r_overflow  <= 1'b0;
        end else begin
            // Sticky from the first cycle a flagged term is on the output, stalled or not.
            if ((r_state == RUN) && r_a_flag) begin
                r_overflow <= 1'b1;
            end
            if (w_hs) begin
                r_a         <= r_b;
                r_b         <= w_b_next;
                r_a_flag    <= r_b_flag;
                r_b_flag    <= w_b_next_flag;
                r_idx       <= r_idx + IDX_W'(1);
                r_remaining <= r_remaining - IDX_W'(1);
            end
        end
    end

endmodule
